pool_comp_ctrl: RTL and testbench
=================================

// Module: pool_comp_ctrl
// PURPOSE
//  Pooling controller/compute core, next generation: buffers neighbour indices as map addresses and
//  reduces every K accepted OFM vectors per lane, in max or average mode, into one output vector.
//  Sits between the POL index/map fetch path and the pooled-OFM writeback.
//  Full throughput: next group's first beat may be accepted in the cycle the previous result drains.
// PARAMETERS
//  IDX_WIDTH            10  index/address width
//  ACT_WIDTH            8   per-lane activation width, signed two's complement
//  POOL_COMP_CORE       64  number of lanes
//  POOL_MAP_DEPTH_WIDTH 5   K-counter width; index FIFO depth = 2**POOL_MAP_DEPTH_WIDTH
//  ACC_WIDTH  ACT_WIDTH+POOL_MAP_DEPTH_WIDTH  per-lane sum width (derived localparam)
// PORTS
//  clk        in  1                   clock, rising edge
//  rst        in  1                   asynchronous, active-high reset
//  CfgRst     in  1                   synchronous soft clear
//  CfgK       in  POOL_MAP_DEPTH_WIDTH  group size K; 0 treated as 1
//  CfgMode    in  1                   0 = max, 1 = average
//  CfgShift   in  clog2(POOL_MAP_DEPTH_WIDTH+1)  avg right-shift (log2 K)
//  IdxVld/IdxRdy in/out 1             index push handshake
//  Idx        in  IDX_WIDTH           neighbour index
//  AddrVld/AddrRdy out/in 1           address pop handshake
//  Addr       out IDX_WIDTH           FIFO head (first-word fall-through)
//  OfmInVld/OfmInRdy in/out 1         input vector handshake
//  OfmIn      in  ACT_WIDTH*POOL_COMP_CORE  lane i = bits [i*ACT_WIDTH +: ACT_WIDTH]
//  OfmOutVld/OfmOutRdy out/in 1       result handshake
//  OfmOut     out ACT_WIDTH*POOL_COMP_CORE  pooled vector
//  Busy       out 1                   cnt!=0 | OfmOutVld | AddrVld
// BEHAVIOUR
//  Reset (rst): FIFO empty, cnt=0, acc=0, OfmOut=0, OfmOutVld=0 -> AddrVld=0, IdxRdy=1, OfmInRdy=1, Busy=0, Addr=0.
//  CfgRst: same clear on next edge; overrides any same-cycle push/pop/accept/drain (those are dropped).
//  Index FIFO: IdxRdy=!full, AddrVld=!empty, Addr=head. push=IdxVld&IdxRdy, pop=AddrVld&AddrRdy.
//   push+pop same cycle: count unchanged. No bypass: push into empty FIFO visible next cycle.
//   Pointers wrap modulo depth; full when count==depth.
//  Reduction: accept = OfmInVld & OfmInRdy; OfmInRdy = !OfmOutVld | OfmOutRdy.
//   cnt counts 0..Keff-1 (Keff = CfgK?CfgK:1); accept at cnt==0 loads acc=sext(OfmIn), else combines.
//   max: acc_i = signed max(acc_i, in_i). avg: acc_i = acc_i + sext(in_i) in ACC_WIDTH (no overflow by sizing).
//   last = accept & cnt==Keff-1: cnt->0, OfmOut/OfmOutVld load next edge (latency 1 cycle after last beat).
//   OfmOut lane: max -> acc_i (combined with last beat); avg -> sat_ACT(sum_i >>> CfgShift), arithmetic shift
//   (floor), saturate to [-2^(ACT_WIDTH-1), 2^(ACT_WIDTH-1)-1].
//  Output: OfmOutVld held, OfmOut stable until OfmOutRdy. drain & new last same cycle -> reload, Vld stays 1.
//  Stall: OfmOutVld & !OfmOutRdy -> OfmInRdy=0, acc/cnt frozen.
//  Cfg*: sampled every beat; legal to change only when Busy=0, else result undefined (no check).
//  Avg with K not a power of two: floor(sum/2^CfgShift), no error flag.
//  FIFO and reduction paths are independent; ordering between them is the parent's responsibility.
// STRUCTURE
//  pool_pkg: mode constants (POOL_MAX, POOL_AVG), acc_width function, signed saturate function.
//  Sub-module pool_lane (one per lane, generate loop): acc register, max/add mux, shift+saturate.
//  Index FIFO, counter and handshake logic inline in pool_comp_ctrl.
// TESTING
//  1 max, K=4, lane0 in 3,-7,12,5 -> one OfmOutVld, lane0=12, 1 cycle after 4th accept.
//  2 avg, K=4, Shift=2, lane0 in 127,127,127,127 -> 127; in -128,-1,0,0 -> -33 (floor); K=1 passthrough.
//  3 avg sat: ACT_WIDTH=8, K=2, Shift=0, in 100,100 -> 127; -100,-100 -> -128.
//  4 back-pressure: OfmOutRdy=0 for 5 cycles -> OfmInRdy=0, OfmOut stable; Rdy=1 with next group streaming
//    -> zero bubbles, 3 groups of K=2 in 6 consecutive accepts.
//  5 FIFO: push 32 idx -> IdxRdy=0; simultaneous push+pop when full -> pop only; pop order = push order; wrap.
//  6 CfgRst mid-group (cnt=2, FIFO holding 5) -> next cycle Busy=0, AddrVld=0, OfmOutVld=0; async rst mid-drain idem.

Source files
------------

// File: rtl/pool_pkg.sv
// pool_pkg: shared mode encoding and arithmetic helpers for the pooling controller.
package pool_pkg;

    typedef enum logic {POOL_MAX = 1'b0, POOL_AVG = 1'b1} pool_mode_e;

    function automatic int acc_width(input int act_w, input int k_w);
        return act_w + k_w;
    endfunction

    // Clamp a signed value into the range of a w-bit two's complement word.
    function automatic logic signed [31:0] sat_act(input logic signed [31:0] v, input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        return (v > hi) ? hi : (v < lo) ? lo : v;
    endfunction

endpackage

// File: rtl/pool_lane.sv
// pool_lane: one lane of the pooling reduction; accumulates max or sum and registers the pooled result.
module pool_lane
    import pool_pkg::*;
#(
    parameter int ACT_WIDTH   = 8,
    parameter int ACC_WIDTH   = 13,
    parameter int SHIFT_WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_clr,
    input  logic                   i_accept,
    input  logic                   i_first,
    input  logic                   i_last,
    input  logic                   i_mode,
    input  logic [SHIFT_WIDTH-1:0] i_shift,
    input  logic [ACT_WIDTH-1:0]   i_in,
    output logic [ACT_WIDTH-1:0]   o_out
);

    logic signed [ACC_WIDTH-1:0] r_acc;
    logic signed [ACC_WIDTH-1:0] w_in;
    logic signed [ACC_WIDTH-1:0] w_comb;
    logic signed [ACC_WIDTH-1:0] w_sh;
    logic signed [31:0]          w_wide;
    logic [ACT_WIDTH-1:0]        w_res;
    logic [ACT_WIDTH-1:0]        r_out;

    assign w_in   = {{(ACC_WIDTH-ACT_WIDTH){i_in[ACT_WIDTH-1]}}, i_in};
    assign w_comb = i_first ? w_in :
                    (i_mode == POOL_AVG) ? r_acc + w_in :
                    (w_in > r_acc) ? w_in : r_acc;
    assign w_sh   = w_comb >>> i_shift;
    assign w_wide = {{(32-ACC_WIDTH){w_sh[ACC_WIDTH-1]}}, w_sh};
    // In max mode the accumulator never leaves the activation range, so truncation is exact.
    assign w_res  = (i_mode == POOL_AVG) ? ACT_WIDTH'(sat_act(w_wide, ACT_WIDTH)) : w_comb[ACT_WIDTH-1:0];
    assign o_out  = r_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_out <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
            r_out <= '0;
        end else if (i_accept) begin
            r_acc <= w_comb;
            if (i_last) r_out <= w_res;
        end
    end

endmodule

// File: rtl/pool_comp_ctrl.sv
// pool_comp_ctrl: index-to-address FIFO plus K-beat max/average reduction of OFM vectors.
module pool_comp_ctrl
    import pool_pkg::*;
#(
    parameter int IDX_WIDTH            = 10,
    parameter int ACT_WIDTH            = 8,
    parameter int POOL_COMP_CORE       = 64,
    parameter int POOL_MAP_DEPTH_WIDTH = 5,
    localparam int SHIFT_WIDTH         = $clog2(POOL_MAP_DEPTH_WIDTH + 1)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                i_cfg_rst,
    input  logic [POOL_MAP_DEPTH_WIDTH-1:0]     i_cfg_k,
    input  logic                                i_cfg_mode,
    input  logic [SHIFT_WIDTH-1:0]              i_cfg_shift,
    input  logic                                i_idx_vld,
    output logic                                o_idx_rdy,
    input  logic [IDX_WIDTH-1:0]                i_idx,
    output logic                                o_addr_vld,
    input  logic                                i_addr_rdy,
    output logic [IDX_WIDTH-1:0]                o_addr,
    input  logic                                i_ofm_in_vld,
    output logic                                o_ofm_in_rdy,
    input  logic [ACT_WIDTH*POOL_COMP_CORE-1:0] i_ofm_in,
    output logic                                o_ofm_out_vld,
    input  logic                                i_ofm_out_rdy,
    output logic [ACT_WIDTH*POOL_COMP_CORE-1:0] o_ofm_out,
    output logic                                o_busy
);

    localparam int DW        = POOL_MAP_DEPTH_WIDTH;
    localparam int DEPTH     = 2 ** DW;
    localparam int ACC_WIDTH = acc_width(ACT_WIDTH, POOL_MAP_DEPTH_WIDTH);

    logic [IDX_WIDTH-1:0] r_mem [DEPTH];
    logic [DW-1:0]        r_wr;
    logic [DW-1:0]        r_rd;
    logic [DW:0]          r_fcnt;
    logic                 w_push;
    logic                 w_pop;

    assign o_idx_rdy  = r_fcnt != (DW+1)'(DEPTH);
    assign o_addr_vld = r_fcnt != '0;
    assign o_addr     = o_addr_vld ? r_mem[r_rd] : '0;
    assign w_push     = i_idx_vld & o_idx_rdy;
    assign w_pop      = o_addr_vld & i_addr_rdy;

    always_ff @(posedge clk) begin
        if (w_push && !i_cfg_rst) r_mem[r_wr] <= i_idx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr   <= '0;
            r_rd   <= '0;
            r_fcnt <= '0;
        end else if (i_cfg_rst) begin
            r_wr   <= '0;
            r_rd   <= '0;
            r_fcnt <= '0;
        end else begin
            r_wr   <= r_wr + DW'(w_push);
            r_rd   <= r_rd + DW'(w_pop);
            r_fcnt <= r_fcnt + (DW+1)'(w_push) - (DW+1)'(w_pop);
        end
    end

    logic [DW-1:0] r_cnt;
    logic [DW-1:0] w_keff;
    logic          r_out_vld;
    logic          w_accept;
    logic          w_first;
    logic          w_last;

    assign w_keff        = (i_cfg_k == '0) ? DW'(1) : i_cfg_k;
    assign o_ofm_in_rdy  = !r_out_vld | i_ofm_out_rdy;
    assign w_accept      = i_ofm_in_vld & o_ofm_in_rdy;
    assign w_first       = r_cnt == '0;
    assign w_last        = w_accept & (r_cnt == w_keff - DW'(1));
    assign o_ofm_out_vld = r_out_vld;
    assign o_busy        = (r_cnt != '0) | r_out_vld | o_addr_vld;

    // A new last beat in the drain cycle reloads the result, so valid stays high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_out_vld <= 1'b0;
        end else if (i_cfg_rst) begin
            r_cnt     <= '0;
            r_out_vld <= 1'b0;
        end else begin
            r_cnt     <= w_last ? '0 : w_accept ? r_cnt + DW'(1) : r_cnt;
            r_out_vld <= w_last ? 1'b1 : (r_out_vld & i_ofm_out_rdy) ? 1'b0 : r_out_vld;
        end
    end

    for (genvar g = 0; g < POOL_COMP_CORE; g++) begin : g_lane
        pool_lane #(
            .ACT_WIDTH  (ACT_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH),
            .SHIFT_WIDTH(SHIFT_WIDTH)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .i_clr   (i_cfg_rst),
            .i_accept(w_accept),
            .i_first (w_first),
            .i_last  (w_last),
            .i_mode  (i_cfg_mode),
            .i_shift (i_cfg_shift),
            .i_in    (i_ofm_in[g*ACT_WIDTH +: ACT_WIDTH]),
            .o_out   (o_ofm_out[g*ACT_WIDTH +: ACT_WIDTH])
        );
    end

endmodule

// File: tb/tb_pool_comp_ctrl.sv
// tb_pool_comp_ctrl: directed self-checking bench for the pooling controller.
module tb_pool_comp_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         cfg_rst = 1'b0;
    logic [4:0]   cfg_k = 5'd4;
    logic         cfg_mode = 1'b0;
    logic [2:0]   cfg_shift = 3'd0;
    logic         idx_vld = 1'b0;
    logic         idx_rdy;
    logic [9:0]   idx = '0;
    logic         addr_vld;
    logic         addr_rdy = 1'b0;
    logic [9:0]   addr;
    logic         in_vld = 1'b0;
    logic         in_rdy;
    logic [511:0] ofm_in = '0;
    logic         out_vld;
    logic         out_rdy = 1'b0;
    logic [511:0] ofm_out;
    logic         busy;
    int           checks = 0;
    int           errors = 0;
    logic [511:0] held;

    always #5 clk = ~clk;

    pool_comp_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .i_cfg_rst    (cfg_rst),
        .i_cfg_k      (cfg_k),
        .i_cfg_mode   (cfg_mode),
        .i_cfg_shift  (cfg_shift),
        .i_idx_vld    (idx_vld),
        .o_idx_rdy    (idx_rdy),
        .i_idx        (idx),
        .o_addr_vld   (addr_vld),
        .i_addr_rdy   (addr_rdy),
        .o_addr       (addr),
        .i_ofm_in_vld (in_vld),
        .o_ofm_in_rdy (in_rdy),
        .i_ofm_in     (ofm_in),
        .o_ofm_out_vld(out_vld),
        .i_ofm_out_rdy(out_rdy),
        .o_ofm_out    (ofm_out),
        .o_busy       (busy)
    );

    function automatic logic [511:0] rep(input int v);
        logic [7:0] b;
        b = v[7:0];
        return {64{b}};
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One input beat: must be accepted in the very cycle it is offered.
    task automatic beat(input int v);
        ofm_in = rep(v);
        in_vld = 1'b1;
        #1;
        chk("in_rdy_on_beat", 512'(in_rdy), 512'(1));
        @(posedge clk);
        #1;
        in_vld = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        chk("rst_addr_vld", 512'(addr_vld), 512'(0));
        chk("rst_idx_rdy", 512'(idx_rdy), 512'(1));
        chk("rst_in_rdy", 512'(in_rdy), 512'(1));
        chk("rst_busy", 512'(busy), 512'(0));
        chk("rst_addr", 512'(addr), 512'(0));
        chk("rst_out_vld", 512'(out_vld), 512'(0));
        chk("rst_out", ofm_out, '0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // max, K=4
        cfg_mode = 1'b0; cfg_k = 5'd4; out_rdy = 1'b0;
        beat(3); beat(-7); beat(12);
        chk("max_no_early_vld", 512'(out_vld), 512'(0));
        chk("max_busy_mid", 512'(busy), 512'(1));
        beat(5);
        chk("max_vld", 512'(out_vld), 512'(1));
        chk("max_out", ofm_out, rep(12));
        out_rdy = 1'b1;
        tick();
        chk("max_drained", 512'(out_vld), 512'(0));

        // avg, K=4, shift 2
        cfg_mode = 1'b1; cfg_shift = 3'd2;
        beat(127); beat(127); beat(127); beat(127);
        chk("avg_vld", 512'(out_vld), 512'(1));
        chk("avg_127", ofm_out, rep(127));
        beat(-128); beat(-1); beat(0); beat(0);
        chk("avg_floor", ofm_out, rep(-33));
        tick();
        cfg_k = 5'd1; cfg_shift = 3'd0;
        beat(55);
        chk("k1_vld", 512'(out_vld), 512'(1));
        chk("k1_pass", ofm_out, rep(55));
        tick();
        cfg_k = 5'd0;
        beat(-9);
        chk("k0_pass", ofm_out, rep(-9));
        tick();

        // avg saturation, K=2
        cfg_k = 5'd2;
        beat(100); beat(100);
        chk("sat_hi", ofm_out, rep(127));
        beat(-100); beat(-100);
        chk("sat_lo", ofm_out, rep(-128));
        tick();

        // back-pressure and full-throughput streaming, max K=2
        cfg_mode = 1'b0; out_rdy = 1'b0;
        beat(1); beat(2);
        held = ofm_out;
        chk("bp_first", held, rep(2));
        ofm_in = rep(5); in_vld = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_rdy", 512'(in_rdy), 512'(0));
            chk("bp_vld", 512'(out_vld), 512'(1));
            chk("bp_stable", ofm_out, held);
            tick();
        end
        out_rdy = 1'b1;
        beat(5);
        chk("stream_drain", 512'(out_vld), 512'(0));
        beat(6);
        chk("stream_g1", ofm_out, rep(6));
        beat(7); beat(8);
        chk("stream_g2_vld", 512'(out_vld), 512'(1));
        chk("stream_g2", ofm_out, rep(8));
        beat(9); beat(10);
        chk("stream_g3", ofm_out, rep(10));
        tick();
        chk("stream_idle", 512'(busy), 512'(0));

        // index FIFO: fill, push+pop at full, order, wrap
        idx_vld = 1'b1;
        for (int i = 0; i < 32; i++) begin
            idx = 10'(i * 3 + 1);
            tick();
            if (i == 0) begin
                chk("fifo_first_vld", 512'(addr_vld), 512'(1));
                chk("fifo_first_addr", 512'(addr), 512'(1));
            end
        end
        chk("fifo_full", 512'(idx_rdy), 512'(0));
        idx = 10'd999; addr_rdy = 1'b1;
        tick();
        idx_vld = 1'b0;
        chk("fifo_pop_only", 512'(idx_rdy), 512'(1));
        for (int i = 1; i < 32; i++) begin
            chk("fifo_order", 512'(addr), 512'(i * 3 + 1));
            tick();
        end
        chk("fifo_empty", 512'(addr_vld), 512'(0));
        addr_rdy = 1'b0;
        idx_vld = 1'b1;
        for (int i = 0; i < 5; i++) begin
            idx = 10'(700 + i);
            tick();
        end
        idx_vld = 1'b0;
        chk("fifo_wrap_head", 512'(addr), 512'(700));

        // CfgRst mid-group with FIFO holding 5
        cfg_k = 5'd4;
        beat(20); beat(30);
        chk("clr_pre_busy", 512'(busy), 512'(1));
        cfg_rst = 1'b1;
        tick();
        cfg_rst = 1'b0;
        chk("clr_busy", 512'(busy), 512'(0));
        chk("clr_addr_vld", 512'(addr_vld), 512'(0));
        chk("clr_out_vld", 512'(out_vld), 512'(0));
        beat(-1); beat(-2);
        chk("clr_cnt_restart", 512'(out_vld), 512'(0));
        beat(-3); beat(-4);
        chk("clr_new_vld", 512'(out_vld), 512'(1));
        chk("clr_new_out", ofm_out, rep(-1));

        // async reset while a result is waiting to drain
        out_rdy = 1'b0;
        tick();
        chk("arst_pre_vld", 512'(out_vld), 512'(1));
        #2 rst = 1'b1;
        #1;
        chk("arst_vld", 512'(out_vld), 512'(0));
        chk("arst_busy", 512'(busy), 512'(0));
        chk("arst_out", ofm_out, '0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
